reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with asynchronous reset, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard. It replaces the fixed 16×16 register file in the CPU datapath. It provides two combinational read ports and one synchronous write port. The scoreboard lets multi-cycle producers reserve a destination register, and it tells the decode stage whether either source operand is still outstanding.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and reservations
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- RegWrite  in  1  write enable
- writeReg  in  ADDR_W  write address
- writeValue  in  DATA_W  write data
- RsvEn  in  1  reserve enable: mark RsvReg pending
- RsvReg  in  ADDR_W  register to reserve
- srcA  in  ADDR_W  read address A
- srcB  in  ADDR_W  read address B
- ReadA  out  DATA_W  data for srcA (combinational)
- ReadB  out  DATA_W  data for srcB (combinational)
- PendA  out  1  srcA has an outstanding producer (combinational)
- PendB  out  1  srcB has an outstanding producer (combinational)
- Busy  out  1  OR of all pending bits (registered state, no bypass term)

## Operation
- State: `regs[NUM_REGS]` of DATA_W bits, plus `pend[NUM_REGS]` of 1 bit each.
- Reset (RST=1, asynchronous):
  - All regs = 0 and all pend = 0, immediately, independent of CLK.
  - Outputs during reset: ReadA/ReadB = 0, PendA/PendB = 0, Busy = 0.
- Write (RegWrite=1 at the edge):
  - regs[writeReg] <= writeValue.
  - pend[writeReg] <= 0, unless it is reserved in the same cycle (see below).
- Reserve (RsvEn=1 at the edge): pend[RsvReg] <= 1.
- RegWrite and RsvEn to the same register in the same cycle:
  - Data is written.
  - pend ends at 1, because the new reservation wins.
- RegWrite and RsvEn to different registers: both take effect independently.
- ZERO_REG=1:
  - Writes and reservations to address 0 are dropped.
  - ReadX for srcX=0 is 0 and PendX is 0.
  - Bypass never applies to address 0.
- Read, with BYPASS=1:
  - If RegWrite=1 and writeReg==srcX (and the address is not a zero-reg), then ReadX = writeValue and PendX = 0.
  - Otherwise ReadX = regs[srcX] and PendX = pend[srcX].
- Read, with BYPASS=0: ReadX = regs[srcX] and PendX = pend[srcX]. A write becomes visible only after the edge.
- An RsvEn in the current cycle never affects PendA/PendB in that cycle; it is visible from the next cycle.
- A write to a non-pending register is legal and simply clears nothing.
- srcA==srcB is legal; both ports return identical values.
- All address values are in range, because NUM_REGS = 2**ADDR_W.

## Timing
- Write latency: data is stored at the rising edge where RegWrite=1.
  - BYPASS=1: visible at ReadX in the same cycle (combinational path writeValue → ReadX).
  - BYPASS=0: visible from the cycle after the edge.
- Reserve latency: pend is set at the edge; PendX and Busy go high from the next cycle.
- Clear latency: pend is cleared at the write edge; Busy falls the cycle after the last pending register is written.
- Read paths are purely combinational from srcX, regs and pend, with no added cycles.
- RST asserted mid-operation:
  - All state clears immediately.
  - Any write or reserve coinciding with the edge while RST=1 is discarded.
- RST deasserted: the first edge with RST=0 performs normal updates.

## Test plan
- Reset then read:
  - Stimulus: assert RST, release it, then read srcA=3, srcB=15.
  - Required: ReadA=0, ReadB=0, PendA=PendB=0, Busy=0.
- Write/read with BYPASS=1:
  - Stimulus: write r5=0xBEEF with srcA=5 in the same cycle.
  - Required: ReadA=0xBEEF in that cycle.
  - Repeat with BYPASS=0: ReadA=0 in that cycle, then 0xBEEF the next cycle.
- Scoreboard:
  - Stimulus: RsvEn r7, then 3 idle cycles with srcB=7, then write r7=0x1234.
  - Required:
    - PendB=1 and Busy=1 during the idle cycles.
    - PendB=0 and ReadB=0x1234 in the write cycle (BYPASS=1).
    - Busy=0 on the following cycle.
- Simultaneous write + reserve:
  - Stimulus: r2 is pending; write r2=0x00AA with RsvEn r2 in the same cycle.
  - Required: next cycle regs[2]=0x00AA, PendA(srcA=2)=1, Busy=1.
- ZERO_REG=1:
  - Stimulus: write r0=0xFFFF and reserve r0.
  - Required: ReadA(srcA=0)=0, PendA=0, Busy=0 on all cycles, including the write cycle.
- Asynchronous reset mid-operation:
  - Stimulus: r1=0x0042, r9 pending; assert RST between clock edges.
  - Required:
    - ReadA(srcA=1)=0 and Busy=0 before the next edge.
    - A write issued during RST is not stored.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: write, reserve and dual-read bus of the register file scoreboard.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              RegWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeValue;
    logic              RsvEn;
    logic [ADDR_W-1:0] RsvReg;
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [DATA_W-1:0] ReadA;
    logic [DATA_W-1:0] ReadB;
    logic              PendA;
    logic              PendB;
    logic              Busy;

    modport master (
        output RegWrite, writeReg, writeValue, RsvEn, RsvReg, srcA, srcB,
        input  ReadA, ReadB, PendA, PendB, Busy
    );
    modport slave (
        input  RegWrite, writeReg, writeValue, RsvEn, RsvReg, srcA, srcB,
        output ReadA, ReadB, PendA, PendB, Busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one write port,
// optional hardwired zero register, optional write bypass and a pending scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    reg_file_sb_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic                w_wr_ok, w_rsv_ok;
    logic                w_zero_a, w_zero_b, w_byp_a, w_byp_b;

    assign w_wr_ok  = bus.RegWrite && !(ZERO_REG != 0 && bus.writeReg == '0);
    assign w_rsv_ok = bus.RsvEn && !(ZERO_REG != 0 && bus.RsvReg == '0);

    // the reservation is assigned last so it wins over a same-register write clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[bus.writeReg] <= bus.writeValue;
                r_pend[bus.writeReg] <= 1'b0;
            end
            if (w_rsv_ok) r_pend[bus.RsvReg] <= 1'b1;
        end
    end

    assign w_zero_a = ZERO_REG != 0 && bus.srcA == '0;
    assign w_zero_b = ZERO_REG != 0 && bus.srcB == '0;
    assign w_byp_a  = BYPASS != 0 && w_wr_ok && bus.writeReg == bus.srcA;
    assign w_byp_b  = BYPASS != 0 && w_wr_ok && bus.writeReg == bus.srcB;

    // reset also masks the bypass path so all outputs read zero while held
    assign bus.ReadA = (i_rst || w_zero_a) ? '0 : w_byp_a ? bus.writeValue : r_regs[bus.srcA];
    assign bus.ReadB = (i_rst || w_zero_b) ? '0 : w_byp_b ? bus.writeValue : r_regs[bus.srcB];
    assign bus.PendA = !(i_rst || w_zero_a || w_byp_a) && r_pend[bus.srcA];
    assign bus.PendB = !(i_rst || w_zero_b || w_byp_b) && r_pend[bus.srcB];
    assign bus.Busy  = |r_pend;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: drives a bypass/no-zero instance and a zero-reg/no-bypass instance
// with identical stimulus and checks both against a behavioural model.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, rsv = 1'b0;
    logic [3:0]  wa = '0, ra = '0, sa = '0, sb = '0;
    logic [15:0] wv = '0;
    int          total = 0;
    int          bad = 0;

    logic [15:0] m_regs [2][16];
    logic        m_pend [2][16];

    always #5 clk = ~clk;

    reg_file_sb_if ifa ();
    reg_file_sb_if ifb ();

    assign ifa.RegWrite = we;  assign ifb.RegWrite = we;
    assign ifa.writeReg = wa;  assign ifb.writeReg = wa;
    assign ifa.writeValue = wv; assign ifb.writeValue = wv;
    assign ifa.RsvEn = rsv;    assign ifb.RsvEn = rsv;
    assign ifa.RsvReg = ra;    assign ifb.RsvReg = ra;
    assign ifa.srcA = sa;      assign ifb.srcA = sa;
    assign ifa.srcB = sb;      assign ifb.srcB = sb;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_byp (.i_clk(clk), .i_rst(rst), .bus(ifa));
    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_zr  (.i_clk(clk), .i_rst(rst), .bus(ifb));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 16; r++) begin
                m_regs[c][r] = '0;
                m_pend[c][r] = 1'b0;
            end
    endfunction

    // config 0: bypass, no zero register; config 1: zero register, no bypass
    function automatic void exp_port(int c, logic [3:0] s, output logic [15:0] d, output logic p);
        bit zr = (c == 1), bp = (c == 0);
        if (rst || (zr && s == 0)) begin
            d = '0; p = 1'b0;
        end else if (bp && we && wa == s) begin
            d = wv; p = 1'b0;
        end else begin
            d = m_regs[c][s]; p = m_pend[c][s];
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < 2; c++) begin
            if (we && !(c == 1 && wa == 0)) begin
                m_regs[c][wa] = wv;
                m_pend[c][wa] = 1'b0;
            end
            if (rsv && !(c == 1 && ra == 0)) m_pend[c][ra] = 1'b1;
        end
    endfunction

    task automatic check_all(string tag);
        logic [15:0] da, db;
        logic        pa, pb, busy;
        for (int c = 0; c < 2; c++) begin
            exp_port(c, sa, da, pa);
            exp_port(c, sb, db, pb);
            busy = 1'b0;
            for (int r = 0; r < 16; r++) busy |= m_pend[c][r];
            if (rst) busy = 1'b0;
            chk($sformatf("%s.c%0d.ReadA", tag, c), c == 0 ? ifa.ReadA : ifb.ReadA, da);
            chk($sformatf("%s.c%0d.ReadB", tag, c), c == 0 ? ifa.ReadB : ifb.ReadB, db);
            chk($sformatf("%s.c%0d.PendA", tag, c), c == 0 ? ifa.PendA : ifb.PendA, pa);
            chk($sformatf("%s.c%0d.PendB", tag, c), c == 0 ? ifa.PendB : ifb.PendB, pb);
            chk($sformatf("%s.c%0d.Busy", tag, c), c == 0 ? ifa.Busy : ifb.Busy, busy);
        end
    endtask

    task automatic drv(logic w, logic [3:0] a, logic [15:0] v, logic r, logic [3:0] rr,
                       logic [3:0] s_a, logic [3:0] s_b);
        we = w; wa = a; wv = v; rsv = r; ra = rr; sa = s_a; sb = s_b;
    endtask

    task automatic step(string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    initial begin
        model_clear();
        drv(1, 3, 16'h1234, 1, 3, 3, 15);
        step("reset_hold");
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 3, 15);
        step("reset_read");
        drv(1, 5, 16'hBEEF, 0, 0, 5, 0);
        step("wr_same_cycle");
        drv(0, 0, 0, 0, 0, 5, 5);
        step("wr_next_cycle");
        drv(0, 0, 0, 1, 7, 0, 7);
        step("rsv_r7");
        repeat (3) begin
            drv(0, 0, 0, 0, 0, 7, 7);
            step("idle_pend_r7");
        end
        drv(1, 7, 16'h1234, 0, 0, 0, 7);
        step("clear_r7");
        drv(0, 0, 0, 0, 0, 7, 7);
        step("busy_fall");
        drv(0, 0, 0, 1, 2, 2, 2);
        step("rsv_r2");
        drv(1, 2, 16'h00AA, 1, 2, 2, 3);
        step("wr_rsv_r2");
        drv(0, 0, 0, 0, 0, 2, 2);
        step("after_wr_rsv");
        drv(1, 2, 16'h0001, 0, 0, 2, 2);
        step("drain_r2");
        drv(1, 0, 16'hFFFF, 1, 0, 0, 0);
        step("zero_wr_rsv");
        drv(0, 0, 0, 0, 0, 0, 0);
        step("zero_after");
        drv(1, 0, 16'h0000, 0, 0, 0, 1);
        step("zero_cleanup");
        drv(1, 1, 16'h0042, 1, 9, 1, 9);
        step("pre_async");
        drv(0, 0, 0, 0, 0, 1, 9);
        step("pre_async_read");
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("async_mid");
        drv(1, 1, 16'h0055, 1, 4, 1, 4);
        step("async_wr_held");
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 1, 4);
        step("async_released");
        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(0, 1), 4'($urandom), 16'($urandom), $urandom_range(0, 2) == 0,
                4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                model_clear();
            end
            step("rand");
            rst = 1'b0;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
